// File: rtl/sram_block_fetch.sv
// rtl/sram_block_fetch.sv - copies one coefficient block per Start from SRAM into a ping-pong DP-RAM
// Walks Y, U, V blocks in raster order; the matrix engine consumes the opposite bank.
module sram_block_fetch #(
  parameter int BLOCK_DIM     = 8,
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 18,
  parameter int DP_ADDR_W     = 7,
  parameter int SRAM_LATENCY  = 2,
  parameter int Y_WIDTH       = 320,
  parameter int Y_HEIGHT      = 240,
  parameter int PRE_IDCT_BASE = 76800
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Frame_done,
  output logic                 Bank,
  output logic [1:0]           Plane,
  output logic [7:0]           Block_col,
  output logic [7:0]           Block_row,
  output logic [ADDR_W-1:0]    SRAM_address,
  input  logic [DATA_W-1:0]    SRAM_read_data,
  output logic                 SRAM_we_n,
  output logic [DP_ADDR_W-1:0] DP_address,
  output logic [31:0]          DP_write_data,
  output logic                 DP_write_enable
);
  localparam int LOG2_DIM = $clog2(BLOCK_DIM);
  localparam int CNT_W    = 2 * LOG2_DIM;
  localparam int NPIX     = BLOCK_DIM * BLOCK_DIM;

  localparam logic [CNT_W-1:0]     LAST_IDX    = CNT_W'(NPIX - 1);
  localparam logic [CNT_W-1:0]     DRAIN_LAST  = CNT_W'(SRAM_LATENCY - 1);
  localparam logic [7:0]           Y_LAST_COL  = 8'(Y_WIDTH / BLOCK_DIM - 1);
  localparam logic [7:0]           UV_LAST_COL = 8'(Y_WIDTH / 2 / BLOCK_DIM - 1);
  localparam logic [7:0]           LAST_ROW    = 8'(Y_HEIGHT / BLOCK_DIM - 1);
  localparam logic [ADDR_W-1:0]    Y_W         = ADDR_W'(Y_WIDTH);
  localparam logic [ADDR_W-1:0]    UV_W        = ADDR_W'(Y_WIDTH / 2);
  localparam logic [ADDR_W-1:0]    Y_BASE      = ADDR_W'(PRE_IDCT_BASE);
  localparam logic [ADDR_W-1:0]    U_BASE      = ADDR_W'(PRE_IDCT_BASE + Y_WIDTH * Y_HEIGHT);
  localparam logic [ADDR_W-1:0]    V_BASE      = ADDR_W'(PRE_IDCT_BASE + Y_WIDTH * Y_HEIGHT
                                                         + (Y_WIDTH / 2) * Y_HEIGHT);
  localparam logic [ADDR_W-1:0]    DIM_A       = ADDR_W'(BLOCK_DIM);
  localparam logic [DP_ADDR_W-1:0] BANK_OFS    = DP_ADDR_W'(NPIX);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               bank_q, bank_d;
  logic [1:0]         plane_q, plane_d;
  logic [7:0]         col_q, col_d;
  logic [7:0]         row_q, row_d;
  logic               issue_load;
  logic [7:0]         last_col;
  logic [LOG2_DIM-1:0] r_idx, c_idx;
  logic [ADDR_W-1:0]  plane_w, plane_base, line_a;

  logic [SRAM_LATENCY-1:0] tag_v_q;
  logic [CNT_W-1:0]        tag_idx_q [SRAM_LATENCY];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    bank_d     = bank_q;
    plane_d    = plane_q;
    col_d      = col_q;
    row_d      = row_q;
    issue_load = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    Frame_done = 1'b0;
    last_col   = (plane_q == 2'd0) ? Y_LAST_COL : UV_LAST_COL;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d    = S_ISSUE;
          cnt_d      = '0;
          issue_load = 1'b1;
        end
      end
      S_ISSUE: begin
        Busy = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          issue_load = 1'b1;
        end
      end
      S_DRAIN: begin
        Busy = 1'b1;
        if (cnt_q == DRAIN_LAST) state_d = S_DONE;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end
      S_DONE: begin
        Done    = 1'b1;
        state_d = S_IDLE;
        bank_d  = ~bank_q;
        // Raster advance: column, then row, then plane; wrapping out of V ends the frame.
        if (col_q != last_col) begin
          col_d = col_q + 8'd1;
        end else begin
          col_d = '0;
          if (row_q != LAST_ROW) begin
            row_d = row_q + 8'd1;
          end else begin
            row_d = '0;
            if (plane_q == 2'd2) begin
              plane_d    = 2'd0;
              Frame_done = 1'b1;
            end else begin
              plane_d = plane_q + 2'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Address for the sample index being registered this edge (cnt_d), so it appears next cycle.
    r_idx      = cnt_d[CNT_W-1:LOG2_DIM];
    c_idx      = cnt_d[LOG2_DIM-1:0];
    plane_w    = (plane_q == 2'd0) ? Y_W : UV_W;
    plane_base = (plane_q == 2'd0) ? Y_BASE : ((plane_q == 2'd1) ? U_BASE : V_BASE);
    line_a     = ADDR_W'(row_q) * DIM_A + ADDR_W'(r_idx);
    if (issue_load)
      addr_d = plane_base + line_a * plane_w + ADDR_W'(col_q) * DIM_A + ADDR_W'(c_idx);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      bank_q  <= 1'b0;
      plane_q <= 2'd0;
      col_q   <= '0;
      row_q   <= '0;
      tag_v_q <= '0;
      for (int i = 0; i < SRAM_LATENCY; i++) tag_idx_q[i] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      plane_q <= plane_d;
      col_q   <= col_d;
      row_q   <= row_d;
      // Tag for the address on the bus this cycle; it reaches the head as its data returns.
      tag_v_q[0]   <= (state_q == S_ISSUE);
      tag_idx_q[0] <= cnt_q;
      for (int i = 1; i < SRAM_LATENCY; i++) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  assign Bank            = bank_q;
  assign Plane           = plane_q;
  assign Block_col       = col_q;
  assign Block_row       = row_q;
  assign SRAM_address    = addr_q;
  assign SRAM_we_n       = 1'b1;
  assign DP_write_enable = tag_v_q[SRAM_LATENCY-1];
  assign DP_address      = tag_v_q[SRAM_LATENCY-1]
                           ? ((bank_q ? BANK_OFS : '0) + DP_ADDR_W'(tag_idx_q[SRAM_LATENCY-1]))
                           : '0;
  assign DP_write_data   = tag_v_q[SRAM_LATENCY-1]
                           ? {{(32-DATA_W){SRAM_read_data[DATA_W-1]}}, SRAM_read_data}
                           : '0;

endmodule

// File: tb/tb_sram_block_fetch.sv
// tb/tb_sram_block_fetch.sv - bench for sram_block_fetch: default instance plus a small-frame latency-3 instance
module tb_sram_block_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, start_a, start_b;
  logic a_busy, a_done, a_fd, a_bank, a_we_n, a_we;
  logic b_busy, b_done, b_fd, b_bank, b_we_n, b_we;
  logic [1:0] a_plane, b_plane;
  logic [7:0] a_col, a_row, b_col, b_row;
  logic [17:0] a_addr, b_addr;
  logic [15:0] a_rd, b_rd;
  logic [6:0] a_dpa, b_dpa;
  logic [31:0] a_dpd, b_dpd;

  sram_block_fetch dut_a (
    .Clock(clk), .Reset(rst_a), .Start(start_a), .Busy(a_busy), .Done(a_done),
    .Frame_done(a_fd), .Bank(a_bank), .Plane(a_plane), .Block_col(a_col), .Block_row(a_row),
    .SRAM_address(a_addr), .SRAM_read_data(a_rd), .SRAM_we_n(a_we_n),
    .DP_address(a_dpa), .DP_write_data(a_dpd), .DP_write_enable(a_we));

  sram_block_fetch #(.SRAM_LATENCY(3), .Y_WIDTH(32), .Y_HEIGHT(16), .PRE_IDCT_BASE(500)) dut_b (
    .Clock(clk), .Reset(rst_b), .Start(start_b), .Busy(b_busy), .Done(b_done),
    .Frame_done(b_fd), .Bank(b_bank), .Plane(b_plane), .Block_col(b_col), .Block_row(b_row),
    .SRAM_address(b_addr), .SRAM_read_data(b_rd), .SRAM_we_n(b_we_n),
    .DP_address(b_dpa), .DP_write_data(b_dpd), .DP_write_enable(b_we));

  int n_checks = 0;
  int n_err = 0;
  int sel = 0;
  bit const_mode = 1'b0;
  logic [15:0] const_val = '0;
  logic [31:0] const_exp = '0;
  logic [15:0] salt = '0;

  function automatic logic [15:0] mem_word(logic [17:0] a, logic [15:0] s);
    return (a[15:0] * 16'h9E37) ^ s;
  endfunction

  // SRAM: content is a hash of the address, returned a fixed number of cycles later.
  logic [17:0] ah_a [2];
  logic [17:0] ah_b [3];
  always @(posedge clk) begin
    ah_a[0] <= a_addr; ah_a[1] <= ah_a[0];
    ah_b[0] <= b_addr; ah_b[1] <= ah_b[0]; ah_b[2] <= ah_b[1];
  end
  assign a_rd = const_mode ? const_val : mem_word(ah_a[1], salt);
  assign b_rd = mem_word(ah_b[2], salt);

  logic o_busy, o_done, o_fd, o_bank, o_we;
  logic [1:0] o_plane;
  logic [7:0] o_col, o_row;
  logic [17:0] o_addr;
  logic [6:0] o_dpa;
  logic [31:0] o_dpd;
  assign o_busy  = sel != 0 ? b_busy  : a_busy;
  assign o_done  = sel != 0 ? b_done  : a_done;
  assign o_fd    = sel != 0 ? b_fd    : a_fd;
  assign o_bank  = sel != 0 ? b_bank  : a_bank;
  assign o_we    = sel != 0 ? b_we    : a_we;
  assign o_plane = sel != 0 ? b_plane : a_plane;
  assign o_col   = sel != 0 ? b_col   : a_col;
  assign o_row   = sel != 0 ? b_row   : a_row;
  assign o_addr  = sel != 0 ? b_addr  : a_addr;
  assign o_dpa   = sel != 0 ? b_dpa   : a_dpa;
  assign o_dpd   = sel != 0 ? b_dpd   : a_dpd;

  function automatic int cfg_w(int d);    return d != 0 ? 32 : 320;     endfunction
  function automatic int cfg_h(int d);    return d != 0 ? 16 : 240;     endfunction
  function automatic int cfg_base(int d); return d != 0 ? 500 : 76800;  endfunction

  // Reference: block n since reset -> plane/col/row by plain division over the frame layout.
  function automatic void model_pos(input int d, input int n, output int pl, output int co,
                                    output int ro, output bit last);
    int w, h, ty, tuv, k;
    w = cfg_w(d); h = cfg_h(d);
    ty = (w / 8) * (h / 8);
    tuv = (w / 16) * (h / 8);
    k = n % (ty + 2 * tuv);
    last = (k == ty + 2 * tuv - 1);
    if (k < ty) begin
      pl = 0; co = k % (w / 8); ro = k / (w / 8);
    end else begin
      k = k - ty;
      pl = 1 + k / tuv;
      k = k % tuv;
      co = k % (w / 16); ro = k / (w / 16);
    end
  endfunction

  function automatic int model_addr(int d, int pl, int co, int ro, int i);
    int w, h, pw, pb;
    w = cfg_w(d); h = cfg_h(d);
    pw = (pl == 0) ? w : w / 2;
    pb = cfg_base(d) + ((pl > 0) ? w * h : 0) + ((pl > 1) ? (w / 2) * h : 0);
    return pb + (ro * 8 + i / 8) * pw + co * 8 + i % 8;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp, input string note = "");
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d %s", name, act, exp, note);
    end
  endtask

  // One fetch on instance d as block number n; every cycle is compared with the model.
  task automatic run_fetch(input int d, input int n, output int f_addr, output int f_pl,
                           output int f_co, output int f_ro, output int f_fd);
    int lat, pl, co, ro, idx, addr_err, wr_err, ctl_err;
    bit last, exp_we, exp_done;
    logic [31:0] exp_data;
    string an, wn, cn;
    lat = (d != 0) ? 3 : 2;
    addr_err = 0; wr_err = 0; ctl_err = 0;
    an = ""; wn = ""; cn = "";
    f_addr = -1; f_pl = -1; f_co = -1; f_ro = -1; f_fd = -1;
    model_pos(d, n, pl, co, ro, last);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    if (!const_mode) salt = 16'($urandom);
    sel = d;
    if (d != 0) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    for (int j = 0; j <= 64 + lat; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 0) begin
        f_addr = int'(o_addr); f_pl = int'(o_plane); f_co = int'(o_col); f_ro = int'(o_row);
      end
      if (j < 64 && o_addr !== 18'(model_addr(d, pl, co, ro, j))) begin
        if (addr_err == 0) an = $sformatf("(j=%0d addr=%0d want %0d)", j, o_addr, model_addr(d, pl, co, ro, j));
        addr_err++;
      end
      exp_we = (j >= lat) && (j < lat + 64);
      exp_done = (j == 64 + lat);
      if (o_we !== exp_we || o_done !== exp_done || o_busy !== !exp_done ||
          o_fd !== (exp_done && last) || o_bank !== 1'(n % 2) || o_plane !== 2'(pl) ||
          o_col !== 8'(co) || o_row !== 8'(ro)) begin
        if (ctl_err == 0)
          cn = $sformatf("(j=%0d we=%b done=%b busy=%b fd=%b bank=%b pos=%0d/%0d/%0d want %0d/%0d/%0d)",
                         j, o_we, o_done, o_busy, o_fd, o_bank, o_plane, o_col, o_row, pl, co, ro);
        ctl_err++;
      end
      if (exp_we) begin
        idx = j - lat;
        exp_data = const_mode ? const_exp
                 : 32'($signed(mem_word(18'(model_addr(d, pl, co, ro, idx)), salt)));
        if (o_dpa !== 7'((n % 2) * 64 + idx) || o_dpd !== exp_data) begin
          if (wr_err == 0)
            wn = $sformatf("(j=%0d dpa=%0d dpd=%h want %0d %h)", j, o_dpa, o_dpd, (n % 2) * 64 + idx, exp_data);
          wr_err++;
        end
      end
      if (exp_done) f_fd = int'(o_fd);
    end
    chk($sformatf("addr_seq d%0d n%0d", d, n), addr_err, 0, an);
    chk($sformatf("dp_writes d%0d n%0d", d, n), wr_err, 0, wn);
    chk($sformatf("control d%0d n%0d", d, n), ctl_err, 0, cn);
    @(negedge clk);
    chk($sformatf("bank_toggle d%0d n%0d", d, n), o_bank, (n + 1) % 2);
    chk($sformatf("idle_quiet d%0d n%0d", d, n), {o_done, o_we, o_busy}, 0);
    chk($sformatf("addr_hold d%0d n%0d", d, n), o_addr, model_addr(d, pl, co, ro, 63));
  endtask

  typedef struct {
    int d; int n; int addr; int pl; int co; int ro; int fd;
  } pos_vec_t;

  typedef struct {
    logic [15:0] din;
    logic [31:0] dout;
  } sext_vec_t;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pos_vec_t pos_tab[$];
    sext_vec_t sext_tab[$];
    int cnt_f[2];
    int fa, fp, fc, fr, ffd, first_d, second_d, dcount, extra;

    pos_tab.push_back('{0, 0, 76800, 0, 0, 0, 0});
    pos_tab.push_back('{0, 1, 76808, 0, 1, 0, 0});
    pos_tab.push_back('{0, 39, 77112, 0, 39, 0, 0});
    pos_tab.push_back('{0, 40, 79360, 0, 0, 1, 0});
    pos_tab.push_back('{0, 41, 79368, 0, 1, 1, 0});
    pos_tab.push_back('{1, 0, 500, 0, 0, 0, 0});
    pos_tab.push_back('{1, 3, 524, 0, 3, 0, 0});
    pos_tab.push_back('{1, 4, 756, 0, 0, 1, 0});
    pos_tab.push_back('{1, 8, 1012, 1, 0, 0, 0});
    pos_tab.push_back('{1, 10, 1140, 1, 0, 1, 0});
    pos_tab.push_back('{1, 12, 1268, 2, 0, 0, 0});
    pos_tab.push_back('{1, 15, 1404, 2, 1, 1, 1});
    pos_tab.push_back('{1, 16, 500, 0, 0, 0, 0});

    sext_tab.push_back('{16'h8001, 32'hFFFF8001});
    sext_tab.push_back('{16'h7FFF, 32'h00007FFF});
    sext_tab.push_back('{16'h0000, 32'h00000000});
    sext_tab.push_back('{16'hFFFF, 32'hFFFFFFFF});
    sext_tab.push_back('{16'h8000, 32'hFFFF8000});

    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    cnt_f[0] = 0; cnt_f[1] = 0;
    repeat (2) @(negedge clk);
    chk("rst_a_zero", ((|{a_busy, a_done, a_fd, a_bank, a_plane, a_col, a_row, a_addr, a_dpa, a_dpd, a_we}) === 1'b0), 1);
    chk("rst_a_we_n", a_we_n, 1);
    chk("rst_b_zero", ((|{b_busy, b_done, b_fd, b_bank, b_plane, b_col, b_row, b_addr, b_dpa, b_dpd, b_we}) === 1'b0), 1);
    chk("rst_b_we_n", b_we_n, 1);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    foreach (pos_tab[t]) begin
      while (cnt_f[pos_tab[t].d] < pos_tab[t].n) begin
        run_fetch(pos_tab[t].d, cnt_f[pos_tab[t].d], fa, fp, fc, fr, ffd);
        cnt_f[pos_tab[t].d]++;
      end
      run_fetch(pos_tab[t].d, pos_tab[t].n, fa, fp, fc, fr, ffd);
      cnt_f[pos_tab[t].d]++;
      chk($sformatf("pos%0d_first_addr", t), fa, pos_tab[t].addr);
      chk($sformatf("pos%0d_plane", t), fp, pos_tab[t].pl);
      chk($sformatf("pos%0d_col", t), fc, pos_tab[t].co);
      chk($sformatf("pos%0d_row", t), fr, pos_tab[t].ro);
      chk($sformatf("pos%0d_frame_done", t), ffd, pos_tab[t].fd);
    end

    const_mode = 1'b1;
    foreach (sext_tab[t]) begin
      const_val = sext_tab[t].din;
      const_exp = sext_tab[t].dout;
      run_fetch(0, cnt_f[0], fa, fp, fc, fr, ffd);
      cnt_f[0]++;
    end
    const_mode = 1'b0;

    // Start held high: one fetch per IDLE entry, back-to-back with one IDLE cycle between.
    sel = 0;
    dcount = 0; first_d = -1; second_d = -1;
    start_a = 1'b1;
    for (int j = 0; j < 200 && dcount < 2; j++) begin
      @(negedge clk);
      if (a_done === 1'b1) begin
        if (dcount == 0) first_d = j; else second_d = j;
        dcount++;
      end
    end
    start_a = 1'b0;
    chk("hold_done_count", dcount, 2);
    chk("hold_first_done", first_d, 66);
    chk("hold_spacing", second_d - first_d, 68);
    extra = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (a_done !== 1'b0 || a_busy !== 1'b0) extra++;
    end
    chk("hold_no_extra_fetch", extra, 0);
    cnt_f[0] += 2;
    chk("hold_bank", a_bank, cnt_f[0] % 2);

    // Reset in the middle of ISSUE discards the block.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_reset_busy", a_busy, 1);
    rst_a = 1'b1;
    #1;
    chk("midrst_zero", ((|{a_busy, a_done, a_fd, a_bank, a_plane, a_col, a_row, a_addr, a_dpa, a_dpd, a_we}) === 1'b0), 1);
    chk("midrst_we_n", a_we_n, 1);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    extra = 0;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (a_done !== 1'b0 || a_we !== 1'b0 || a_busy !== 1'b0) extra++;
    end
    chk("midrst_no_done", extra, 0);
    cnt_f[0] = 0;
    run_fetch(0, 0, fa, fp, fc, fr, ffd);
    cnt_f[0]++;
    chk("midrst_refetch_addr", fa, 76800);
    chk("midrst_refetch_plane", fp, 0);

    while (cnt_f[1] < 40) begin
      run_fetch(1, cnt_f[1], fa, fp, fc, fr, ffd);
      cnt_f[1]++;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
